// File: rtl/fsk_symbol_scheduler.sv
// rtl/fsk_symbol_scheduler.sv - FSK symbol scheduler: frames stream bytes into paced mark/space DDS phase increments
module fsk_symbol_scheduler #(
    parameter int                PINC_W       = 40,
    parameter int                DIV_W        = 16,
    parameter int                PREAMBLE_LEN = 8,
    parameter logic [PINC_W-1:0] MARK_DEF     = 40'h00_0A3D_70A4,
    parameter logic [PINC_W-1:0] SPACE_DEF    = 40'h00_147A_E148,
    parameter int                DIV_DEF      = 64
) (
    input  logic              clk_in1,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [PINC_W-1:0] cfg_wdata,
    input  logic [7:0]        s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [PINC_W-1:0] pinc_tdata,
    output logic              pinc_tvalid,
    output logic              bit_out,
    output logic              sym_strobe,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, PRE, START, DATA, STOP} state_t;

    localparam logic [7:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 8'(PREAMBLE_LEN - 1) : 8'd0;

    state_t            state, next_state;
    logic [DIV_W-1:0]  cnt;
    logic [7:0]        pre_idx;
    logic [7:0]        shreg;
    logic [2:0]        idx;
    logic [PINC_W-1:0] mark_reg, space_reg;
    logic [DIV_W-1:0]  div_reg, div_eff;
    logic              sym_end, hs, sym_start, next_bit;
    logic [PINC_W-1:0] mark_live;

    assign sym_end  = (cnt == '0);
    assign s_tready = pinc_tvalid && ((state == IDLE) || (state == STOP && sym_end));
    assign hs       = s_tvalid && s_tready;
    assign div_eff  = (div_reg < DIV_W'(2)) ? DIV_W'(2) : div_reg;
    // Idle output follows a mark write on the very next cycle.
    assign mark_live = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : mark_reg;

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            mark_reg  <= MARK_DEF;
            space_reg <= SPACE_DEF;
            div_reg   <= DIV_W'(DIV_DEF);
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    mark_reg  <= cfg_wdata;
                2'd1:    space_reg <= cfg_wdata;
                2'd2:    div_reg   <= cfg_wdata[DIV_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (hs) next_state = (PREAMBLE_LEN > 0) ? PRE : START;
            PRE:   if (sym_end && pre_idx == PRE_LAST) next_state = START;
            START: if (sym_end) next_state = DATA;
            DATA:  if (sym_end && idx == 3'd7) next_state = STOP;
            STOP:  if (sym_end) next_state = hs ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sym_start = (state == IDLE) ? hs : (sym_end && next_state != IDLE);
        next_bit  = 1'b1;
        case (next_state)
            PRE:   next_bit = (state == IDLE) ? 1'b1 : pre_idx[0];
            START: next_bit = 1'b0;
            DATA:  next_bit = (state == START) ? shreg[0] : shreg[1];
            default: next_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pre_idx <= '0;
            shreg   <= '0;
            idx     <= '0;
        end else begin
            if (sym_start)
                cnt <= div_eff - DIV_W'(1);
            else if (state != IDLE && !sym_end)
                cnt <= cnt - DIV_W'(1);

            if (state == IDLE && hs)
                pre_idx <= '0;
            else if (state == PRE && sym_end)
                pre_idx <= pre_idx + 8'd1;

            if (hs)
                shreg <= s_tdata;
            else if (state == DATA && sym_end)
                shreg <= {1'b0, shreg[7:1]};

            if (state == START && sym_end)
                idx <= '0;
            else if (state == DATA && sym_end)
                idx <= idx + 3'd1;
        end
    end

    // Increment is sampled once per symbol so config writes land on the next symbol.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            pinc_tvalid <= 1'b0;
            bit_out     <= 1'b1;
            pinc_tdata  <= MARK_DEF;
            sym_strobe  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pinc_tvalid <= 1'b1;
            sym_strobe  <= sym_start;
            busy        <= (next_state != IDLE);
            if (sym_start) begin
                bit_out    <= next_bit;
                pinc_tdata <= next_bit ? mark_reg : space_reg;
            end else if (next_state == IDLE) begin
                bit_out    <= 1'b1;
                pinc_tdata <= mark_live;
            end
        end
    end

endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// tb/tb_fsk_symbol_scheduler.sv - scoreboard bench for fsk_symbol_scheduler
module tb_fsk_symbol_scheduler;

    localparam int          PRE_LEN   = 8;
    localparam logic [39:0] MARK_DEF  = 40'h00_0A3D_70A4;
    localparam logic [39:0] SPACE_DEF = 40'h00_147A_E148;

    logic        clk_in1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [39:0] cfg_wdata = '0;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready, pinc_tvalid, bit_out, sym_strobe, busy;
    logic [39:0] pinc_tdata;

    always #5 clk_in1 = ~clk_in1;

    fsk_symbol_scheduler dut (
        .clk_in1(clk_in1), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .pinc_tdata(pinc_tdata), .pinc_tvalid(pinc_tvalid), .bit_out(bit_out),
        .sym_strobe(sym_strobe), .busy(busy)
    );

    typedef struct packed {
        logic        b;
        logic [39:0] pinc;
        logic [31:0] len;
        logic        stable;
    } sym_t;

    sym_t exp_q[$];
    sym_t obs_q[$];
    sym_t cur, o, e;
    logic cur_open = 1'b0;
    int   busy_cnt = 0;
    int   rd_idx = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [39:0] m_mark = MARK_DEF;
    logic [39:0] m_space = SPACE_DEF;
    int   m_div = 64;

    // Monitor: records each transmitted symbol (value, increment, length, stability).
    initial begin
        forever begin
            @(negedge clk_in1);
            if (!rst_n) begin
                cur_open = 1'b0;
            end else begin
                if (busy) busy_cnt = busy_cnt + 1;
                if (sym_strobe) begin
                    if (cur_open) obs_q.push_back(cur);
                    cur.b = bit_out; cur.pinc = pinc_tdata; cur.len = 32'd1; cur.stable = 1'b1;
                    cur_open = 1'b1;
                end else if (cur_open && busy) begin
                    cur.len = cur.len + 32'd1;
                    if (bit_out !== cur.b || pinc_tdata !== cur.pinc) cur.stable = 1'b0;
                end else if (cur_open) begin
                    obs_q.push_back(cur);
                    cur_open = 1'b0;
                end
            end
        end
    end

    task automatic push_sym(input logic b);
        sym_t s;
        s.b = b; s.pinc = b ? m_mark : m_space; s.len = 32'(m_div); s.stable = 1'b1;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pre);
        if (pre) for (int i = 0; i < PRE_LEN; i++) push_sym(i % 2 == 0);
        push_sym(1'b0);
        for (int i = 0; i < 8; i++) push_sym(d[i]);
        push_sym(1'b1);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [39:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk_in1);
        cfg_we = 1'b0;
        if (a == 2'd0) m_mark = d;
        if (a == 2'd1) m_space = d;
        if (a == 2'd2) m_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ok);
        s_tdata = d; s_tvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (s_tready) ok = 1'b1;
            else @(negedge clk_in1);
        end
        @(negedge clk_in1);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_in1);
            if (!busy) ok = 1'b1;
        end
        @(negedge clk_in1);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk_in1);
        n_checks++;
        if ({s_tready, pinc_tvalid, bit_out, sym_strobe, busy} !== 5'b00100) begin
            n_fail++; $display("FAIL reset_flags: got %b, want 00100", {s_tready, pinc_tvalid, bit_out, sym_strobe, busy});
        end
        n_checks++;
        if (pinc_tdata !== MARK_DEF) begin n_fail++; $display("FAIL reset_pinc: got %h, want %h", pinc_tdata, MARK_DEF); end
        rst_n = 1'b1;
        @(negedge clk_in1);
        n_checks++;
        if ({pinc_tvalid, s_tready, busy} !== 3'b110) begin
            n_fail++; $display("FAIL post_reset_flags: got %b, want 110", {pinc_tvalid, s_tready, busy});
        end
        n_checks++;
        if (pinc_tdata !== MARK_DEF) begin n_fail++; $display("FAIL post_reset_pinc: got %h, want %h", pinc_tdata, MARK_DEF); end
    endtask

    task automatic test_frame;
        logic ok;
        int b0;
        cfg_write(2'd2, 40'd4);
        push_frame(8'hA5, 1'b1);
        b0 = busy_cnt;
        send_byte(8'hA5, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL frame_accept: got timeout, want handshake"); end
        n_checks++;
        if ({sym_strobe, busy, bit_out} !== 3'b111 || pinc_tdata !== MARK_DEF) begin
            n_fail++; $display("FAIL frame_latency: got strobe/busy/bit=%b pinc=%h, want 111 %h", {sym_strobe, busy, bit_out}, pinc_tdata, MARK_DEF);
        end
        wait_idle(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL frame_idle: got timeout, want busy low"); end
        n_checks++;
        if (busy_cnt - b0 != 72) begin n_fail++; $display("FAIL frame_busy_len: got %0d, want 72", busy_cnt - b0); end
        while (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx]; rd_idx++; n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL frame_sym extra: got bit=%0b, want none", o.b); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL frame_sym: got bit=%0b pinc=%h len=%0d stable=%0b, want bit=%0b pinc=%h len=%0d stable=1", o.b, o.pinc, o.len, o.stable, e.b, e.pinc, e.len); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_sym missing: got %0d left, want 0", exp_q.size()); exp_q.delete(); end
        n_checks++;
        if ({bit_out, s_tready} !== 2'b11 || pinc_tdata !== MARK_DEF) begin
            n_fail++; $display("FAIL frame_end_idle: got bit/ready=%b pinc=%h, want 11 %h", {bit_out, s_tready}, pinc_tdata, MARK_DEF);
        end
    endtask

    task automatic test_back_to_back;
        logic ok;
        int b0;
        push_frame(8'h00, 1'b1);
        push_frame(8'hFF, 1'b0);
        b0 = busy_cnt;
        send_byte(8'h00, ok);
        s_tdata = 8'hFF; s_tvalid = 1'b1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_first_accept: got timeout, want handshake"); end
        send_byte(8'hFF, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_second_accept: got timeout, want handshake"); end
        wait_idle(400, ok);
        n_checks++;
        if (busy_cnt - b0 != 112) begin n_fail++; $display("FAIL b2b_busy_len: got %0d, want 112", busy_cnt - b0); end
        while (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx]; rd_idx++; n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sym extra: got bit=%0b, want none", o.b); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL b2b_sym: got bit=%0b pinc=%h len=%0d stable=%0b, want bit=%0b pinc=%h len=%0d stable=1", o.b, o.pinc, o.len, o.stable, e.b, e.pinc, e.len); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_sym missing: got %0d left, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_idle_cfg;
        cfg_write(2'd0, 40'h12_3456_789A);
        n_checks++;
        if (pinc_tdata !== 40'h12_3456_789A) begin n_fail++; $display("FAIL idle_mark_write: got %h, want 123456789a", pinc_tdata); end
        cfg_write(2'd3, 40'h1);
        @(negedge clk_in1);
        n_checks++;
        if (pinc_tdata !== 40'h12_3456_789A) begin n_fail++; $display("FAIL idle_addr3_noop: got %h, want 123456789a", pinc_tdata); end
        cfg_write(2'd0, MARK_DEF);
        n_checks++;
        if (pinc_tdata !== MARK_DEF) begin n_fail++; $display("FAIL idle_mark_restore: got %h, want %h", pinc_tdata, MARK_DEF); end
    endtask

    task automatic test_holdoff;
        logic ok;
        int b0;
        push_frame(8'h6E, 1'b1);
        b0 = busy_cnt;
        send_byte(8'h6E, ok);
        repeat (5) @(negedge clk_in1);
        s_tdata = 8'hFF; s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (s_tready !== 1'b0) begin n_fail++; $display("FAIL holdoff_ready cycle %0d: got %b, want 0", i, s_tready); end
            @(negedge clk_in1);
        end
        s_tvalid = 1'b0;
        wait_idle(300, ok);
        n_checks++;
        if (busy_cnt - b0 != 72) begin n_fail++; $display("FAIL holdoff_busy_len: got %0d, want 72", busy_cnt - b0); end
        while (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx]; rd_idx++; n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL holdoff_sym extra: got bit=%0b, want none", o.b); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL holdoff_sym: got bit=%0b pinc=%h len=%0d stable=%0b, want bit=%0b pinc=%h len=%0d stable=1", o.b, o.pinc, o.len, o.stable, e.b, e.pinc, e.len); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL holdoff_sym missing: got %0d left, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_div_space;
        logic ok;
        cfg_write(2'd2, 40'd0);
        push_frame(8'h0F, 1'b1);
        for (int k = 13; k <= 16; k++) exp_q[k].pinc = 40'h1;
        send_byte(8'h0F, ok);
        repeat (17) @(negedge clk_in1);
        cfg_write(2'd1, 40'h1);
        wait_idle(200, ok);
        cfg_write(2'd1, SPACE_DEF);
        cfg_write(2'd2, 40'd1);
        push_frame(8'h96, 1'b1);
        send_byte(8'h96, ok);
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL div_idle: got timeout, want busy low"); end
        while (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx]; rd_idx++; n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL div_sym extra: got bit=%0b, want none", o.b); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL div_sym: got bit=%0b pinc=%h len=%0d stable=%0b, want bit=%0b pinc=%h len=%0d stable=1", o.b, o.pinc, o.len, o.stable, e.b, e.pinc, e.len); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL div_sym missing: got %0d left, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid;
        logic ok;
        int b0;
        cfg_write(2'd2, 40'd4);
        send_byte(8'h33, ok);
        repeat (40) @(negedge clk_in1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_tready, pinc_tvalid, bit_out, sym_strobe, busy} !== 5'b00100 || pinc_tdata !== MARK_DEF) begin
            n_fail++; $display("FAIL midreset_outputs: got flags=%b pinc=%h, want 00100 %h", {s_tready, pinc_tvalid, bit_out, sym_strobe, busy}, pinc_tdata, MARK_DEF);
        end
        repeat (3) @(negedge clk_in1);
        rd_idx = obs_q.size();
        m_mark = MARK_DEF; m_space = SPACE_DEF; m_div = 64;
        rst_n = 1'b1;
        @(negedge clk_in1);
        cfg_write(2'd2, 40'd4);
        push_frame(8'h81, 1'b1);
        b0 = busy_cnt;
        send_byte(8'h81, ok);
        wait_idle(300, ok);
        n_checks++;
        if (busy_cnt - b0 != 72) begin n_fail++; $display("FAIL midreset_busy_len: got %0d, want 72", busy_cnt - b0); end
        while (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx]; rd_idx++; n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL midreset_sym extra: got bit=%0b, want none", o.b); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL midreset_sym: got bit=%0b pinc=%h len=%0d stable=%0b, want bit=%0b pinc=%h len=%0d stable=1", o.b, o.pinc, o.len, o.stable, e.b, e.pinc, e.len); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_sym missing: got %0d left, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_idle_cfg();
        test_holdoff();
        test_div_space();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsk_symbol_scheduler.md
# fsk_symbol_scheduler

Sequencing controller for the FSK modulator's DDS phase-increment input. It accepts bytes over a valid/ready stream and frames each burst as preamble, start bit, 8 data bits LSB-first and stop bit. Symbols are paced by a programmable baud divisor. Per symbol it drives the 40-bit mark or space phase increment directly into the DDS `s_axis_phase_tdata`/`tvalid`, which removes the bit-indexed BRAM lookup and the free-running bit input.

## Interface
- PINC_W, 40, phase-increment width; matches the DDS phase port.
- DIV_W, 16, baud divisor width.
- PREAMBLE_LEN, 8, number of alternating preamble symbols, starting with 1; legal range 0..255.
- MARK_DEF, 40'h00_0A3D_70A4, reset value of the mark (bit 1) increment.
- SPACE_DEF, 40'h00_147A_E148, reset value of the space (bit 0) increment.
- DIV_DEF, 64, reset baud divisor, in clocks per symbol.

- clk_in1  in  1  single system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select: 0 = mark, 1 = space, 2 = baud divisor, 3 = ignored.
- cfg_wdata  in  PINC_W  config data; the divisor uses bits [DIV_W-1:0].
- s_tdata  in  8  byte to transmit.
- s_tvalid  in  1  byte valid.
- s_tready  out  1  byte accepted when high together with s_tvalid.
- pinc_tdata  out  PINC_W  phase increment to the DDS.
- pinc_tvalid  out  1  phase-increment valid.
- bit_out  out  1  current symbol value (1 = mark).
- sym_strobe  out  1  one-cycle pulse on the first cycle of every transmitted symbol.
- busy  out  1  high while a frame or burst is in progress.

## Operation
- FSM states: IDLE, PRE, START, DATA, STOP.
- Each symbol lasts exactly `div_eff` cycles, where `div_eff = max(baud_div, 2)`. A down-counter loads `div_eff-1` at symbol start; the symbol ends on the cycle the counter reads 0.
- IDLE transitions:
  - Handshake with PREAMBLE_LEN > 0 → PRE.
  - Handshake with PREAMBLE_LEN = 0 → START.
  - The byte is latched into a shift register.
- PRE: emits PREAMBLE_LEN symbols 1,0,1,0,… then → START.
- START: emits one symbol of value 0, then → DATA.
- DATA: emits 8 symbols, LSB first, with a 3-bit index; after the symbol for index 7 → STOP.
- STOP: emits one symbol of value 1. At its end:
  - Handshake in that cycle → START. No preamble within a burst.
  - Otherwise → IDLE.
- IDLE output: bit_out = 1; pinc_tdata tracks the mark register.
- Symbol/increment mapping: pinc_tdata = bit_out ? mark : space, sampled once at symbol start. Mark/space/divisor writes during a symbol take effect at the next symbol start. In IDLE they take effect on the next cycle.
- cfg writes never stall or abort a frame. cfg_addr = 3 is a no-op.
- s_tvalid while not ready is held off; the data is not sampled.

## Timing
- Reset values, applied while rst_n = 0 and asynchronously on assertion:
  - state IDLE, s_tready 0, pinc_tvalid 0, bit_out 1, sym_strobe 0, busy 0, pinc_tdata MARK_DEF.
  - Config registers return to MARK_DEF, SPACE_DEF, DIV_DEF.
- First cycle after release: pinc_tvalid = 1 and stays 1. s_tready = 1 in IDLE.
- s_tready is asserted in IDLE, or in the final cycle of a STOP symbol. It is low otherwise.
- Latency: handshake in cycle T. At T+1, bit_out and pinc_tdata show the first symbol, sym_strobe = 1 and busy = 1.
- Frame length from IDLE: (PREAMBLE_LEN + 10)·div_eff cycles. Each back-to-back byte adds 10·div_eff cycles.
- busy falls on the cycle IDLE is re-entered. bit_out and pinc_tdata return to mark that same cycle.
- A config write in the same cycle as a symbol start does not affect that symbol.
- Reset mid-frame: the frame is dropped and no partial byte is retained.

## Test plan
- Reset with rst_n = 0 for 5 cycles → outputs hold reset values. After release: pinc_tvalid = 1 and s_tready = 1, and pinc_tdata = MARK_DEF.
- Set baud_div = 4, PREAMBLE_LEN = 8, send 0xA5 → bit_out sequence 1,0,1,0,1,0,1,0, 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. Also expect 18 sym_strobe pulses, busy high for exactly 72 cycles, and pinc_tdata = mark/space matching each bit.
- Burst 0x00 then 0xFF, with s_tvalid held → second frame START follows STOP with no preamble. Total busy = (8+20)·4 = 112 cycles.
- Write baud_div = 0, then 1 → symbols last 2 cycles. Write space = 40'h1 mid-DATA → change appears only on the next 0-symbol start.
- Pulse rst_n low during DATA → outputs go to reset values immediately. A new byte after release is framed from the preamble.
- Drive s_tvalid while busy, outside the STOP final cycle → no acceptance, and the transmitted frame is unchanged.
